// File: rtl/paper_counter_bank_if.sv
// Bus bundle for paper_counter_bank: control inputs and counter/status outputs.
interface paper_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 2,
    parameter int SEL_W  = 2
);
    logic [NUM_CH-1:0]       inc;
    logic [NUM_CH-1:0]       clr;
    logic                    load_en;
    logic [SEL_W-1:0]        load_sel;
    logic [WIDTH-1:0]        load_val;
    logic                    sticky_clr;
    logic [SEL_W-1:0]        rd_sel;
    logic [NUM_CH*WIDTH-1:0] count_flat;
    logic [NUM_CH-1:0]       ovf_pulse;
    logic [NUM_CH-1:0]       ovf_sticky;
    logic                    any_ovf;
    logic [WIDTH-1:0]        rd_data;

    modport master (
        output inc, clr, load_en, load_sel, load_val, sticky_clr, rd_sel,
        input  count_flat, ovf_pulse, ovf_sticky, any_ovf, rd_data
    );

    modport slave (
        input  inc, clr, load_en, load_sel, load_val, sticky_clr, rd_sel,
        output count_flat, ovf_pulse, ovf_sticky, any_ovf, rd_data
    );
endinterface

// File: rtl/paper_counter_bank.sv
// Bank of NUM_CH independent WIDTH-bit paper-event counters with clear/load,
// optional ripple cascade, wrap or saturate at max, overflow pulse/sticky
// flags and a registered read port.
module paper_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 2,
    parameter int SATURATE = 0,
    parameter int CASCADE  = 0,
    parameter int SEL_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    paper_counter_bank_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX = '1;

    if (CASCADE != 0 && SATURATE != 0) begin : g_bad_cfg
        $error("paper_counter_bank: CASCADE=1 cannot be combined with SATURATE=1");
    end

    logic [WIDTH-1:0]  count     [NUM_CH];
    logic [WIDTH-1:0]  count_nxt [NUM_CH];
    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] sticky_nxt;
    logic [WIDTH-1:0]  rd_nxt;

    // Per-channel next state; the cascade carry is walked through a local
    // variable so the ripple is evaluated in channel order within one pass.
    always_comb begin
        logic cin;
        logic eff;
        logic load_hit;
        logic at_max;
        cin = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load_hit = bus.load_en && (32'(bus.load_sel) == i);
            at_max   = (count[i] == MAX);
            eff      = bus.inc[i] | ((CASCADE != 0) && cin);
            ovf_evt[i] = eff && at_max && !bus.clr[i] && !load_hit;
            cin = (SATURATE == 0) ? ovf_evt[i] : 1'b0;

            if (bus.clr[i])
                count_nxt[i] = '0;
            else if (load_hit)
                count_nxt[i] = bus.load_val;
            else if (eff)
                count_nxt[i] = at_max ? ((SATURATE != 0) ? MAX : '0)
                                      : count[i] + WIDTH'(1);
            else
                count_nxt[i] = count[i];

            // A fresh overflow beats any clear on the same edge.
            sticky_nxt[i] = ovf_evt[i] |
                            (bus.ovf_sticky[i] & ~bus.clr[i] & ~bus.sticky_clr);
        end
    end

    // Read mux over pre-update counter values; out-of-range selects read 0.
    always_comb begin
        rd_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(bus.rd_sel) == i)
                rd_nxt = count[i];
        end
    end

    // Counter, flag and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                count[i] <= '0;
            bus.ovf_pulse  <= '0;
            bus.ovf_sticky <= '0;
            bus.rd_data    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                count[i] <= count_nxt[i];
            bus.ovf_pulse  <= ovf_evt;
            bus.ovf_sticky <= sticky_nxt;
            bus.rd_data    <= rd_nxt;
        end
    end

    // Flattened counter view and overflow summary.
    always_comb begin
        bus.count_flat = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            bus.count_flat[i*WIDTH +: WIDTH] = count[i];
        bus.any_ovf = |bus.ovf_sticky;
    end

endmodule
